// File: rtl/gray_if.sv
// Handshake bundle between the frame-buffer read stream, the controller and the
// downstream gray-pixel consumer.
//   start              controller request to convert one frame
//   in_valid/in_data   RGB byte stream (R,G,B per pixel) from the frame buffer
//   pause              stall request back to the frame buffer
//   out_valid/out_data gray pixel offered downstream
//   out_ready          downstream accepts out_data
//   busy/done          status to the controller
interface gray_if;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       pause;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       done;

    // Side that drives the stream, the request and the downstream ready.
    modport master (
        output start, in_valid, in_data, out_ready,
        input  pause, out_valid, out_data, busy, done
    );

    // The converter itself.
    modport slave (
        input  start, in_valid, in_data, out_ready,
        output pause, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/gray_converter.sv
// RGB-to-luminance converter on the read side of the RGB frame buffer.
// Pulls one frame of N*M pixels as an R,G,B byte stream, stalls the stream with
// pause while it cannot take a byte, and hands each gray pixel downstream with a
// valid/ready handshake. A one-cycle done pulse follows the last handoff.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    gray_if.slave: start, in_valid/in_data, pause, out_valid/out_data,
//          out_ready, busy, done
module gray_converter #(
    parameter int unsigned N  = 2,
    parameter int unsigned M  = 2,
    parameter int unsigned PW = $clog2(N*M+1)
) (
    input  logic  clk,
    input  logic  rst_n,
    gray_if.slave bus
);
    localparam int unsigned NPIX = N * M;

    typedef enum logic [2:0] {
        IDLE,
        GET_R,
        GET_G,
        GET_B,
        CALC,
        SEND,
        FIN
    } state_t;

    state_t        state;
    logic [PW-1:0] pix_cnt;
    logic [7:0]    r_q;
    logic [7:0]    g_q;
    logic [7:0]    b_q;
    logic          out_valid_q;
    logic [7:0]    out_data_q;
    logic          done_q;
    logic [15:0]   sum_c;

    // Fixed-point luminance weights (sum to 256); the max result 65280 fits 16 bits.
    assign sum_c = 16'd77  * 16'(r_q)
                 + 16'd150 * 16'(g_q)
                 + 16'd29  * 16'(b_q);

    // Sequencer: byte collection, conversion, handoff and completion pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        pix_cnt <= '0;
                        state   <= GET_R;
                    end
                end
                GET_R: begin
                    if (bus.in_valid) begin
                        r_q   <= bus.in_data;
                        state <= GET_G;
                    end
                end
                GET_G: begin
                    if (bus.in_valid) begin
                        g_q   <= bus.in_data;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (bus.in_valid) begin
                        b_q   <= bus.in_data;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // Keep the upper byte: divide by 256 with truncation.
                    out_data_q  <= 8'(sum_c >> 8);
                    out_valid_q <= 1'b1;
                    pix_cnt     <= pix_cnt + PW'(1);
                    state       <= SEND;
                end
                SEND: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (pix_cnt == PW'(NPIX)) begin
                            // done rises on the same edge out_valid falls, so never overlaps.
                            done_q <= 1'b1;
                            state  <= FIN;
                        end else begin
                            state <= GET_R;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // pause and busy are pure decodes of the state flops, no input feedthrough.
    assign bus.pause     = !(state inside {GET_R, GET_G, GET_B});
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_gray_converter.sv
`timescale 1ns/1ps
module tb_gray_converter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    gray_if g1();
    gray_if g2();

    // Single-pixel frame instance and default 2x2 frame instance.
    gray_converter #(.N(1), .M(1)) u_px (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (g1)
    );

    gray_converter u_frm (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (g2)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int gray(input int r, input int g, input int b);
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle2(input string tag);
        chk({tag, "_pause"}, 32'(g2.pause), 1);
        chk({tag, "_busy"},  32'(g2.busy), 0);
        chk({tag, "_ov"},    32'(g2.out_valid), 0);
        chk({tag, "_done"},  32'(g2.done), 0);
    endtask

    // One 1x1 frame with an always-valid stream and always-ready sink.
    task automatic px1(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input int exp);
        g1.start = 1'b1;
        tick();
        g1.start = 1'b0;
        chk("px_busy_start", 32'(g1.busy), 1);
        chk("px_pause_get", 32'(g1.pause), 0);
        g1.in_valid = 1'b1;
        g1.in_data  = r;
        tick();
        g1.in_data = g;
        tick();
        g1.in_data = b;
        tick();
        g1.in_valid  = 1'b0;
        g1.out_ready = 1'b1;
        chk("px_ov_after_b", 32'(g1.out_valid), 0);
        chk("px_pause_calc", 32'(g1.pause), 1);
        tick();
        chk("px_ov_rise", 32'(g1.out_valid), 1);
        chk("px_data", 32'(g1.out_data), 32'(exp));
        chk("px_done_early", 32'(g1.done), 0);
        tick();
        chk("px_ov_fall", 32'(g1.out_valid), 0);
        chk("px_done_pulse", 32'(g1.done), 1);
        tick();
        chk("px_done_end", 32'(g1.done), 0);
        chk("px_busy_end", 32'(g1.busy), 0);
    endtask

    // One 2x2 frame with random stalls, stray bytes and mid-frame start pulses.
    // abort_at > 0 resets the design once that many bytes have been consumed.
    task automatic run_frame(input int abort_at, input bit do_hold);
        logic [7:0] bytes [12];
        logic [7:0] m_data;
        int taken, sent, hold_left, cyc, dones;
        bit m_ov, m_done, calc, held, in_v, o_r, acc, hs, fin;
        for (int i = 0; i < 12; i++) bytes[i] = 8'($urandom);
        g2.start = 1'b1;
        tick();
        g2.start = 1'b0;
        taken = 0; sent = 0; hold_left = 0; dones = 0;
        m_ov = 0; m_done = 0; calc = 0; held = 0; m_data = '0;
        for (cyc = 0; cyc < 500; cyc++) begin
            fin = (sent == 4) && !m_done && (dones == 1);
            // Collecting exactly when every finished pixel has been handed off.
            chk("fr_pause", 32'(g2.pause), 32'(!(sent == taken / 3 && taken < 12)));
            chk("fr_ov", 32'(g2.out_valid), 32'(m_ov));
            chk("fr_done", 32'(g2.done), 32'(m_done));
            chk("fr_busy", 32'(g2.busy), 32'(!fin));
            if (m_ov) chk("fr_data", 32'(g2.out_data), 32'(m_data));
            if (fin) break;
            if (abort_at > 0 && taken == abort_at) begin
                rst_n       = 1'b0;
                g2.in_valid = 1'b1;
                g2.start    = 1'b0;
                tick();
                rst_n       = 1'b1;
                g2.in_valid = 1'b0;
                chk("ab_data", 32'(g2.out_data), 0);
                for (int k = 0; k < 6; k++) begin
                    chk_idle2("ab_idle");
                    tick();
                end
                return;
            end
            in_v        = ($urandom_range(3) != 0);
            g2.in_valid = in_v;
            g2.in_data  = (taken < 12) ? bytes[taken] : 8'($urandom);
            if (do_hold && m_ov && sent == 1 && !held) begin
                held = 1;
                hold_left = 7;
            end
            if (hold_left > 0) begin
                o_r = 0;
                hold_left--;
            end else begin
                o_r = ($urandom_range(2) != 0);
            end
            g2.out_ready = o_r;
            g2.start     = (sent < 4) ? ($urandom_range(7) == 0) : 1'b0;
            acc    = (sent == taken / 3 && taken < 12) && in_v;
            hs     = m_ov && o_r;
            m_done = hs && (sent == 3);
            if (hs) begin
                sent++;
                m_ov = 0;
            end
            if (calc) begin
                m_ov   = 1;
                m_data = 8'(gray(int'(bytes[taken-3]), int'(bytes[taken-2]), int'(bytes[taken-1])));
            end
            calc = 0;
            if (acc) begin
                taken++;
                calc = (taken % 3 == 0);
            end
            if (m_done) dones++;
            tick();
        end
        g2.start = 1'b0;
        chk("fr_no_timeout", 32'(cyc < 500), 1);
        chk("fr_pixels", 32'(sent), 4);
        chk("fr_done_count", 32'(dones), 1);
    endtask

    logic [7:0] wr [5];
    logic [7:0] wg [5];
    logic [7:0] wb [5];
    int         we [5];

    initial begin
        wr = '{8'd255, 8'd0,   8'd0,   8'd255, 8'd0};
        wg = '{8'd0,   8'd255, 8'd0,   8'd255, 8'd0};
        wb = '{8'd0,   8'd0,   8'd255, 8'd255, 8'd0};
        we = '{76, 149, 28, 255, 0};

        rst_n = 1'b0;
        g1.start = 1'b0; g1.in_valid = 1'b0; g1.in_data = '0; g1.out_ready = 1'b0;
        g2.start = 1'b0; g2.in_valid = 1'b0; g2.in_data = '0; g2.out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_data", 32'(g2.out_data), 0);
        for (int i = 0; i < 10; i++) begin
            chk_idle2("rst_idle");
            chk("rst_px_pause", 32'(g1.pause), 1);
            chk("rst_px_busy", 32'(g1.busy), 0);
            chk("rst_px_ov", 32'(g1.out_valid), 0);
            chk("rst_px_done", 32'(g1.done), 0);
            tick();
        end

        px1(8'd100, 8'd150, 8'd200, 140);
        for (int i = 0; i < 5; i++) px1(wr[i], wg[i], wb[i], we[i]);

        run_frame(0, 1'b1);
        repeat (2) tick();
        run_frame(5, 1'b0);
        run_frame(0, 1'b0);
        repeat (2) tick();
        run_frame(0, 1'b1);
        chk_idle2("end_idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
